mem_access_ctrl: RTL

- MEM-stage data-memory controller for the 16-bit pipeline; sits between the EX/MEM buffer and the MEM/WB buffer.
- Converts EX/MEM load/store controls into a req/ack transaction on the data-memory bus, which may have variable latency.
- Stalls the upstream pipeline while a transaction is outstanding and presents the formatted load result on rd to the MEM/WB buffer.

---
 rtl/mem_access_ctrl_pkg.sv | 17 +
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl_lane_fmt.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller.
// Covers FSM state encodings, byte-enable codes and timeout sizing.
package mem_defs;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned TMO_W   = 4;
  localparam int unsigned TIMEOUT = 15;

  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] BUSY = 2'd1;
  localparam logic [STATE_W-1:0] DONE = 2'd2;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and memory (slave).
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_access_ctrl_lane_fmt.sv
// Byte-lane formatting for the data-memory controller (combinational).
// It steers store data, generates byte enables, and selects and zero-extends load data.
module mem_lane_fmt
  import mem_defs::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              memByte,
  input  logic              addrLsb,
  input  logic [DATA_W-1:0] wdata,
  output logic [1:0]        storeBe_c,
  output logic [DATA_W-1:0] storeData_c,
  input  logic [1:0]        loadBe,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] loadData_c
);

  localparam int unsigned BYTE_W = 8;

  // Store side: byte stores replicate the low byte into both lanes.
  always_comb begin
    storeBe_c   = BE_WORD;
    storeData_c = wdata;
    if (memByte) begin
      storeBe_c   = addrLsb ? BE_HI : BE_LO;
      storeData_c = {(DATA_W / BYTE_W){wdata[BYTE_W-1:0]}};
    end
  end

  // Load side: the latched byte enable picks the lane to zero-extend.
  always_comb begin
    loadData_c = rdata;
    case (loadBe)
      BE_LO:   loadData_c = DATA_W'(rdata[BYTE_W-1:0]);
      BE_HI:   loadData_c = DATA_W'(rdata[2*BYTE_W-1:BYTE_W]);
      default: loadData_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: turns EX/MEM load/store controls into a
// req/ack bus transaction, stalls upstream while busy, and formats rd.
// Optional bus timeout is enabled with `define MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_defs::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memByte,
  input  logic              kill,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  mem_access_ctrl_if.master bus,
  output logic [DATA_W-1:0] rd,
  output logic              stall,
  output logic              bus_err
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] stateNext;
  logic               start;
  logic               ackHit;
  logic               timeoutHit;
  logic               finish;
  logic [1:0]         storeBe;
  logic [DATA_W-1:0]  storeData;
  logic [DATA_W-1:0]  loadData;

  assign start  = (memRead | memWrite) & ~kill;
  assign ackHit = (state == BUSY) & bus.mem_ack;
  assign finish = ackHit | timeoutHit;

  mem_lane_fmt #(.DATA_W(DATA_W)) u_lane_fmt (
    .memByte     (memByte),
    .addrLsb     (addr[0]),
    .wdata       (wdata),
    .storeBe_c   (storeBe),
    .storeData_c (storeData),
    .loadBe      (bus.mem_be),
    .rdata       (bus.mem_rdata),
    .loadData_c  (loadData)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and combinational stall.
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (finish) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!reset) stall = 1'b0;
  end

  // Bus command registers: latched on start, held until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 2'b00;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if ((state == IDLE) && start) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= memWrite;
      bus.mem_be    <= storeBe;
      bus.mem_addr  <= memByte ? addr : {addr[ADDR_W-1:1], 1'b0};
      bus.mem_wdata <= storeData;
    end else if ((state == BUSY) && finish) begin
      bus.mem_req   <= 1'b0;
    end
  end

  // Load result: only updated on a completed read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    rd <= '0;
    else if (ackHit && !bus.mem_we) rd <= loadData;
  end

`ifdef MEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmoCnt;

  // An ack in the same cycle as the last allowed wait wins over the timeout.
  assign timeoutHit = (state == BUSY) & ~bus.mem_ack & (tmoCnt == TMO_W'(TIMEOUT - 1));

  // Wait counter: zero outside BUSY, counts BUSY cycles without ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           tmoCnt <= '0;
    else if (state != BUSY)               tmoCnt <= '0;
    else if (!bus.mem_ack && !timeoutHit) tmoCnt <= tmoCnt + TMO_W'(1);
  end

  // Abort pulse, high for the DONE cycle after a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err <= 1'b0;
    else        bus_err <= timeoutHit;
  end
`else
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
`endif

endmodule
